// File: rtl/lsu_sram_port_arb_if.sv
// Bundles the write/read requester handshakes, the SRAM macro pins and the
// read-response channel that surround one LSU scratchpad port arbiter.
interface lsu_sram_port_arb_if #(
    parameter int ADDR_W  = 8,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 128
);
    // DRAM load write path
    logic               wr_vld;
    logic               wr_rdy;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WDATA_W-1:0] wr_data;

    // ram_buffer read path
    logic               rd_vld;
    logic               rd_rdy;
    logic [ADDR_W-1:0]  rd_addr;

    // mem_wrapper pins
    logic               sram_cen;
    logic               sram_wen;
    logic [ADDR_W-1:0]  sram_addr;
    logic [WDATA_W-1:0] sram_din;
    logic [RDATA_W-1:0] sram_dout;

    // read response towards ram_buffer
    logic               rsp_vld;
    logic [ADDR_W-1:0]  rsp_addr;
    logic [RDATA_W-1:0] rsp_data;

    modport slave (
        input  wr_vld, wr_addr, wr_data,
        input  rd_vld, rd_addr,
        input  sram_dout,
        output wr_rdy, rd_rdy,
        output sram_cen, sram_wen, sram_addr, sram_din,
        output rsp_vld, rsp_addr, rsp_data
    );

    modport master (
        output wr_vld, wr_addr, wr_data,
        output rd_vld, rd_addr,
        output sram_dout,
        input  wr_rdy, rd_rdy,
        input  sram_cen, sram_wen, sram_addr, sram_din,
        input  rsp_vld, rsp_addr, rsp_data
    );
endinterface

// File: rtl/lsu_sram_port_arb.sv
// Single-port scratchpad arbiter: writes win by default, a starvation counter
// forces a read through, and a one-deep tag pipeline pairs sram_dout with its address.
module lsu_sram_port_arb #(
    parameter int ADDR_W     = 8,
    parameter int WDATA_W    = 32,
    parameter int RDATA_W    = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    lsu_sram_port_arb_if.slave   bus,
    output logic [3:0]           starve_cnt,
    output logic                 arb_idle
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              wr_grant;
    logic              rd_grant;
    logic              starved;
    logic [3:0]        starve_cnt_reg;
    logic [3:0]        starve_cnt_next;
    logic              rsp_vld_reg;
    logic [ADDR_W-1:0] rsp_addr_reg;

    assign starved = (starve_cnt_reg >= STARVE_LIM);

    // Grants are gated by rst_n so nothing reaches the SRAM while reset is held.
    always_comb begin
        wr_grant = rst_n & bus.wr_vld & (~bus.rd_vld | ~starved);
        rd_grant = rst_n & bus.rd_vld & (~bus.wr_vld | starved);
    end

    always_comb begin
        bus.wr_rdy    = wr_grant;
        bus.rd_rdy    = rd_grant;
        bus.sram_cen  = 1'b0;
        bus.sram_wen  = 1'b0;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        if (wr_grant) begin
            bus.sram_cen  = 1'b1;
            bus.sram_wen  = 1'b1;
            bus.sram_addr = bus.wr_addr;
            bus.sram_din  = bus.wr_data;
        end else if (rd_grant) begin
            bus.sram_cen  = 1'b1;
            bus.sram_addr = bus.rd_addr;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (flush || rd_grant || !bus.rd_vld) begin
            starve_cnt_next = 4'd0;
        end else if (wr_grant) begin
            starve_cnt_next = starved ? STARVE_LIM : starve_cnt_reg + 4'd1;
        end
    end

    // A flush seen in the issue cycle kills the response before it is born.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= 4'd0;
            rsp_vld_reg    <= 1'b0;
            rsp_addr_reg   <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rsp_vld_reg    <= rd_grant & ~flush;
            if (rd_grant) begin
                rsp_addr_reg <= bus.rd_addr;
            end
        end
    end

    assign bus.rsp_vld  = rsp_vld_reg & ~flush;
    assign bus.rsp_addr = rsp_addr_reg;
    assign bus.rsp_data = bus.sram_dout;
    assign starve_cnt   = starve_cnt_reg;
    assign arb_idle     = ~rst_n | (~bus.wr_vld & ~bus.rd_vld & ~bus.rsp_vld);
endmodule
